// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, fetch FSM states and the
// instruction field positions used by both fetch and decode.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    REQ_HI,
    WAIT_HI,
    REQ_LO,
    WAIT_LO,
    HOLD
  } fetch_state_e;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RD_MSB  = 26;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS_MSB  = 23;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  function automatic logic [OPC_MSB-OPC_LSB:0] instr_opcode(input logic [31:0] ins);
    return ins[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_mem_req_port.sv
// Memory request port: registered single-cycle start strobe, in-flight flag
// and a capture strobe raised once ready has been seen low and then high again.
module mem_req_port (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic mem_ready,
  output logic mem_start,
  output logic busy,
  output logic done
);

  logic start_q, start_d;
  logic pend_q, pend_d;
  logic low_q, low_d;

  always_comb begin
    start_d = issue;
    pend_d  = pend_q;
    low_d   = low_q;
    // Ready is still high in the cycle the strobe is visible; only a
    // low-then-high sequence marks the returned data.
    done    = pend_q & low_q & mem_ready;
    if (issue) begin
      pend_d = 1'b1;
      low_d  = 1'b0;
    end else if (done) begin
      pend_d = 1'b0;
      low_d  = 1'b0;
    end else if (pend_q && !mem_ready) begin
      low_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      pend_q  <= 1'b0;
      low_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      pend_q  <= pend_d;
      low_q   <= low_d;
    end
  end

  assign mem_start = start_q;
  assign busy      = pend_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Two-word instruction fetch with branch redirect and valid/ready delivery.
// Define FETCH_PERF_CNT_EN to add saturating fetch_count/flush_count outputs.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_rwn,
  output logic                mem_start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]         fetch_count,
  output logic [15:0]         flush_count,
`endif
  output logic                instr_valid,
  output logic [2*DATA_W-1:0] instr,
  output logic [ADDR_W-1:0]   instr_pc,
  input  logic                instr_ready
);

  fetch_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [2*DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic                flush_q, flush_d;
  logic                issue, req_busy, req_done;

  mem_req_port u_req (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue),
    .mem_ready (mem_ready),
    .mem_start (mem_start),
    .busy      (req_busy),
    .done      (req_done)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    flush_d    = flush_q;
    issue      = 1'b0;
    unique case (state_q)
      REQ_HI, REQ_LO: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ_HI;
        end else if (mem_ready && !req_busy) begin
          issue   = 1'b1;
          addr_d  = (state_q == REQ_HI) ? pc_q : pc_q + ADDR_W'(1);
          state_d = (state_q == REQ_HI) ? WAIT_HI : WAIT_LO;
        end
      end
      WAIT_HI, WAIT_LO: begin
        // The bus cycle cannot be aborted: a redirect only retargets pc and
        // marks the returning word for discard.
        if (redirect) begin
          pc_d    = redirect_pc;
          flush_d = !req_done;
          if (req_done) state_d = REQ_HI;
        end else if (req_done) begin
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = REQ_HI;
          end else if (state_q == WAIT_HI) begin
            hi_d    = mem_rdata;
            state_d = REQ_LO;
          end else begin
            instr_d    = {hi_q, mem_rdata};
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = pc_q + ADDR_W'(2);
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = REQ_HI;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = REQ_HI;
        end
      end
      default: state_d = REQ_HI;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= REQ_HI;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      hi_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_rwn     = 1'b1;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic        accept, discard;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // A redirect during an already-flushing wait discards nothing new.
  assign accept  = (state_q == HOLD) && instr_ready && !redirect;
  assign discard = redirect && ((state_q == HOLD) ||
                   (((state_q == WAIT_HI) || (state_q == WAIT_LO)) && !flush_q));

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (accept && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (discard && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural memory with per-address
// busy time, an expected-instruction stream model and a decoupled monitor.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mem_address;
  logic        mem_rwn;
  logic        mem_start;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_address (mem_address),
    .mem_rwn     (mem_rwn),
    .mem_start   (mem_start),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
    .flush_count (flush_count),
`endif
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  // Behavioural memory: samples start on a clock edge, drops ready for the
  // address's busy time, then raises ready with the word on data_out.
  logic [15:0] mem [256];
  int unsigned busy_tab [256];
  int unsigned cnt;
  logic [7:0]  lat_addr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b1;
      cnt       <= 0;
      mem_rdata <= '0;
      lat_addr  <= '0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[lat_addr];
      end
    end else if (mem_start) begin
      mem_ready <= 1'b0;
      cnt       <= busy_tab[mem_address];
      lat_addr  <= mem_address;
    end
  end

  int checks = 0;
  int passes = 0;
  int accepts = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endfunction

  // Expected stream: the next delivered instruction is at the last redirect
  // target, or two words past the last accepted one.
  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] ins;
  } exp_t;
  exp_t exp_q[$];

  function automatic exp_t make_exp(input logic [7:0] pc);
    exp_t e;
    logic [7:0] pc1;
    pc1   = pc + 8'd1;
    e.pc  = pc;
    e.ins = {mem[pc], mem[pc1]};
    return e;
  endfunction

  logic        prev_hold = 1'b0;
  logic [31:0] prev_ins;
  logic [7:0]  prev_pc;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (mem_start) begin
        chk("start_when_idle", {31'd0, mem_ready, 32'(cnt)}, {31'd0, 1'b1, 32'd0});
        chk("rwn", {63'd0, mem_rwn}, 64'd1);
      end
      if (instr_valid) chk("no_start_in_hold", {63'd0, mem_start}, 64'd0);
      if (prev_hold) begin
        chk("hold_valid", {63'd0, instr_valid}, 64'd1);
        chk("hold_instr", {32'd0, instr}, {32'd0, prev_ins});
        chk("hold_pc", {56'd0, instr_pc}, {56'd0, prev_pc});
      end
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_instr: instr_pc=%0h with empty scoreboard", instr_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("instr_pc", {56'd0, instr_pc}, {56'd0, e.pc});
          chk("instr", {32'd0, instr}, {32'd0, e.ins});
          exp_q.push_back(make_exp(e.pc + 8'd2));
        end
        accepts++;
      end
      prev_hold = instr_valid && !instr_ready && !redirect;
      prev_ins  = instr;
      prev_pc   = instr_pc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [7:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    exp_q.delete();
    exp_q.push_back(make_exp(tgt));
    tick();
    redirect = 1'b0;
  endtask

  task automatic wait_accepts(input int target, input string nm);
    int n = 0;
    while (accepts < target && n < 200) begin
      tick();
      n++;
    end
    if (accepts < target) begin
      checks++;
      $display("FAIL timeout_%s: accepts=%0d required %0d", nm, accepts, target);
    end
  endtask

  task automatic wait_start(input logic [7:0] a, input bit need_match, input string nm);
    int n = 0;
    while (!(mem_start && (!need_match || mem_address == a)) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL timeout_%s: no start at address %0h", nm, a);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!instr_valid && n < 200) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      checks++;
      $display("FAIL timeout_%s: instr_valid never rose", nm);
    end
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_start"}, {63'd0, mem_start}, 64'd0);
    chk({nm, "_valid"}, {63'd0, instr_valid}, 64'd0);
    chk({nm, "_instr"}, {32'd0, instr}, 64'd0);
    chk({nm, "_instr_pc"}, {56'd0, instr_pc}, 64'd0);
    chk({nm, "_addr"}, {56'd0, mem_address}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({nm, "_fetch_count"}, {48'd0, fetch_count}, 64'd0);
    chk({nm, "_flush_count"}, {48'd0, flush_count}, 64'd0);
`endif
  endtask

  initial begin
    int base;
    for (int i = 0; i < 256; i++) begin
      mem[i]      = 16'($urandom);
      busy_tab[i] = $urandom_range(1, 4);
    end
    mem[0]  = 16'h6884; mem[1]  = 16'h0004;
    mem[2]  = 16'h6842; mem[3]  = 16'h0002;
    mem[8]  = 16'h8804; mem[9]  = 16'h0400;
    mem[10] = 16'hB140; mem[11] = 16'h0000;

    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    #12;
    check_reset_values("reset");
    exp_q.push_back(make_exp(8'd0));
    tick();
    reset = 1'b0;

    // First fetch, then back-pressure on the second.
    wait_accepts(1, "first");
    instr_ready = 1'b0;
    wait_start(8'd2, 1'b0, "second_start");
    chk("next_addr", {56'd0, mem_address}, 64'd2);
    wait_valid("second");
    repeat (10) tick();
    chk("held_valid", {63'd0, instr_valid}, 64'd1);
    chk("held_pc", {56'd0, instr_pc}, 64'd2);
    instr_ready = 1'b1;
    wait_accepts(2, "second");

    // Redirect while the second word of the fetch at 4 is in flight.
    wait_start(8'd5, 1'b1, "lo_of_4");
    do_redirect(8'd8);
    wait_accepts(3, "after_wait_redirect");
    tick();
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", {48'd0, fetch_count}, 64'd3);
    chk("flush_count", {48'd0, flush_count}, 64'd1);
`endif

    // Redirect in HOLD with ready high: the held instruction is dropped.
    wait_valid("hold_10");
    do_redirect(8'd10);
    chk("discard_valid", {63'd0, instr_valid}, 64'd0);
    wait_accepts(4, "after_hold_redirect");

    // PC wrap: 252, 254, 0.
    do_redirect(8'd252);
    base = accepts;
    wait_accepts(base + 3, "wrap");

    // Randomized traffic with back-pressure and occasional redirects.
    for (int c = 0; c < 600; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) do_redirect(8'($urandom_range(0, 255)));
      else tick();
    end
    instr_ready = 1'b1;
    base = accepts;
    wait_accepts(base + 2, "drain");

    // Asynchronous reset with a transaction in flight.
    wait_start(8'd0, 1'b0, "pre_reset");
    #2 reset = 1'b1;
    #1;
    check_reset_values("midreset");
    exp_q.delete();
    exp_q.push_back(make_exp(8'd0));
    tick();
    reset = 1'b0;
    base = accepts;
    wait_accepts(base + 2, "after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
